dift_tag_check_ctrl: RTL and testbench
======================================

// Module: dift_tag_check_ctrl
// PURPOSE
//  Parametrised, registered successor of the DIFT tag check. Evaluates exec/JALR/branch/store/load
//  tag policies on the ID-stage instruction using TAG_WIDTH-bit tags under a taint mask.
//  Captures the first violation and raises a trap request to the controller with a req/ack handshake.
//  Stalls ID while the trap is pending. Sits between riscv_id_stage and riscv_controller.
// PARAMETERS
//  TAG_WIDTH   4   bits per tag (instr, operand, jump target)
//  CNT_WIDTH   16  width of each per-class violation counter (only with DIFT_VIOLATION_CNT_EN)
// PORTS
//  clk                 in   1          core clock
//  rst_n               in   1          asynchronous reset, active low
//  id_valid_i          in   1          ID instruction valid this cycle (checks qualified by it)
//  pc_id_i             in   32         PC of ID instruction
//  instr_tag_i         in   TAG_WIDTH  fetched instruction tag
//  jump_in_i           in   2          BRANCH_NONE/JAL/JALR/COND encoding
//  jump_target_tag_i   in   TAG_WIDTH  JALR target tag
//  operand_a_tag_i     in   TAG_WIDTH  rs1 tag (branch, load/store address)
//  operand_b_tag_i     in   TAG_WIDTH  rs2 tag (branch)
//  is_load_i/is_store_i in  1 each     opclass decode
//  tag_mask_i          in   TAG_WIDTH  tag bits that count as taint
//  tccr_exec_i, tccr_jalr_i, tccr_store_i, tccr_load_i  in 1 each  check enables
//  tccr_br_mode_i      in   2          0 OFF, 1 OR, 2 AND, 3 SINGLE
//  tccr_br_sel_i       in   1          SINGLE mode: 0 operand A, 1 operand B
//  trap_ack_i          in   1          controller has taken the trap
//  trap_req_o          out  1          trap pending
//  trap_type_o         out  3          0 NONE,1 EXEC,2 JALR,3 BRAN,4 STOR,5 LOAD
//  trap_pc_o           out  32         PC of the violating instruction
//  multi_o             out  1          sticky: violation seen while a trap was pending
//  stall_o             out  1          hold ID stage
//  cnt_clr_i           in   1          clear counters (macro only)
//  cnt_o               out  5*CNT_WIDTH {load,store,bran,jalr,exec} counters (macro only)
// BEHAVIOUR
//  - Tainted(t) = |(t & tag_mask_i). Class results are combinational and qualified by id_valid_i.
//    exec: tccr_exec_i & T(instr). jalr: jump_in_i==JALR & tccr_jalr_i & T(target).
//    bran: jump_in_i==COND; OR/AND of T(a), T(b), or the operand selected in SINGLE mode.
//    store/load: opclass & enable & T(a).
//  - Priority: EXEC > JALR > BRAN > STOR > LOAD. Only the winning class is captured.
//  - FSM IDLE -> REQ when any class result is 1: capture type and pc_id_i. trap_req_o=1 next cycle.
//  - REQ: trap_req_o=1, stall_o=1, capture registers frozen. Any qualified violation sets multi_o.
//    REQ -> IDLE on trap_ack_i. In the ack cycle, trap_type_o/trap_pc_o are still valid.
//    A violation in the ack cycle is not captured; it only sets multi_o.
//  - IDLE: trap_req_o=0, stall_o=0, trap_type_o=NONE. Latency from violation to req: 1 cycle.
//  - multi_o clears when REQ -> IDLE happens without a coincident violation.
//  - trap_ack_i while in IDLE is ignored.
//  - Reset (async, any state): FSM IDLE; trap_req_o=0, stall_o=0, multi_o=0, trap_type_o=0,
//    trap_pc_o=0, counters=0. Pending trap is discarded.
//  - Config inputs are sampled combinationally every cycle. A TCCR change while in REQ does not alter
//    the captured trap.
// CONFIGURATION
//  DIFT_VIOLATION_CNT_EN defined:
//    - Five saturating CNT_WIDTH counters, one per class.
//    - Each counter increments on every qualified violation of its class, in any state and
//      independent of priority.
//    - A counter holds at all-ones.
//    - cnt_clr_i zeroes all counters; if clear and increment coincide, clear wins.
//  Undefined: no counter flops; cnt_o tied to 0; cnt_clr_i ignored.
// TESTING
//  1 mask=4'hF, exec on, instr_tag=4'h1, valid, pc=0x100 -> next cycle req=1, type=1, pc=0x100,
//    stall=1; ack -> IDLE next cycle.
//  2 JALR target tag=4'h2 with exec violation in the same cycle -> type=1 (EXEC priority);
//    counters (macro) exec=1, jalr=1.
//  3 Branch SINGLE sel=1, a=4'h8, b=0 -> no trap; switch to OR mode -> type=3.
//  4 mask=4'h1, store tag a=4'hE -> no trap. mask=4'h2 -> type=4.
//  5 In REQ, load violation -> multi_o=1, captured type/pc unchanged. Ack without violation
//    -> multi_o=0.
//  6 rst_n low mid-REQ -> all outputs 0 immediately. Counter held at 0xFFFF plus an increment
//    -> stays 0xFFFF; clr with an increment -> 0.

Source files
------------

// File: rtl/dift_tag_check_ctrl.sv
// DIFT tag-policy check on the ID-stage instruction with a registered trap req/ack to the controller.
// Optional per-class saturating violation counters under DIFT_VIOLATION_CNT_EN.
module dift_tag_check_ctrl #(
    parameter int unsigned TAG_WIDTH = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid_i,
    input  logic [31:0]            pc_id_i,
    input  logic [TAG_WIDTH-1:0]   instr_tag_i,
    input  logic [1:0]             jump_in_i,
    input  logic [TAG_WIDTH-1:0]   jump_target_tag_i,
    input  logic [TAG_WIDTH-1:0]   operand_a_tag_i,
    input  logic [TAG_WIDTH-1:0]   operand_b_tag_i,
    input  logic                   is_load_i,
    input  logic                   is_store_i,
    input  logic [TAG_WIDTH-1:0]   tag_mask_i,
    input  logic                   tccr_exec_i,
    input  logic                   tccr_jalr_i,
    input  logic                   tccr_store_i,
    input  logic                   tccr_load_i,
    input  logic [1:0]             tccr_br_mode_i,
    input  logic                   tccr_br_sel_i,
    input  logic                   trap_ack_i,
    output logic                   trap_req_o,
    output logic [2:0]             trap_type_o,
    output logic [31:0]            trap_pc_o,
    output logic                   multi_o,
    output logic                   stall_o,
    input  logic                   cnt_clr_i,
    output logic [5*CNT_WIDTH-1:0] cnt_o
);

    localparam int unsigned NUM_CLASSES = 5;

    localparam logic [1:0] JUMP_JALR = 2'b10;
    localparam logic [1:0] JUMP_COND = 2'b11;

    localparam logic [1:0] BR_OFF    = 2'd0;
    localparam logic [1:0] BR_OR     = 2'd1;
    localparam logic [1:0] BR_AND    = 2'd2;

    localparam logic [2:0] TRAP_NONE = 3'd0;
    localparam logic [2:0] TRAP_EXEC = 3'd1;
    localparam logic [2:0] TRAP_JALR = 3'd2;
    localparam logic [2:0] TRAP_BRAN = 3'd3;
    localparam logic [2:0] TRAP_STOR = 3'd4;
    localparam logic [2:0] TRAP_LOAD = 3'd5;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t state_q;

    // Per-class results, bit order {load, store, bran, jalr, exec}
    logic [NUM_CLASSES-1:0] viol_c;
    logic                   any_viol_c;
    logic [2:0]             win_type_c;
    logic                   t_a_c;
    logic                   t_b_c;
    logic                   br_taint_c;

    always_comb begin
        t_a_c      = |(operand_a_tag_i & tag_mask_i);
        t_b_c      = |(operand_b_tag_i & tag_mask_i);
        br_taint_c = 1'b0;
        case (tccr_br_mode_i)
            BR_OFF:  br_taint_c = 1'b0;
            BR_OR:   br_taint_c = t_a_c | t_b_c;
            BR_AND:  br_taint_c = t_a_c & t_b_c;
            default: br_taint_c = tccr_br_sel_i ? t_b_c : t_a_c;
        endcase

        viol_c    = '0;
        viol_c[0] = tccr_exec_i & (|(instr_tag_i & tag_mask_i));
        viol_c[1] = (jump_in_i == JUMP_JALR) & tccr_jalr_i & (|(jump_target_tag_i & tag_mask_i));
        viol_c[2] = (jump_in_i == JUMP_COND) & br_taint_c;
        viol_c[3] = is_store_i & tccr_store_i & t_a_c;
        viol_c[4] = is_load_i & tccr_load_i & t_a_c;
        if (!id_valid_i) begin
            viol_c = '0;
        end
        any_viol_c = |viol_c;
    end

    // Fixed priority EXEC > JALR > BRAN > STOR > LOAD
    always_comb begin
        win_type_c = TRAP_NONE;
        if (viol_c[0])      win_type_c = TRAP_EXEC;
        else if (viol_c[1]) win_type_c = TRAP_JALR;
        else if (viol_c[2]) win_type_c = TRAP_BRAN;
        else if (viol_c[3]) win_type_c = TRAP_STOR;
        else if (viol_c[4]) win_type_c = TRAP_LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            trap_req_o  <= 1'b0;
            stall_o     <= 1'b0;
            trap_type_o <= TRAP_NONE;
            trap_pc_o   <= '0;
            multi_o     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_viol_c) begin
                        state_q     <= REQ;
                        trap_req_o  <= 1'b1;
                        stall_o     <= 1'b1;
                        trap_type_o <= win_type_c;
                        trap_pc_o   <= pc_id_i;
                    end
                end
                REQ: begin
                    // Capture is frozen; further violations only flag multi
                    if (trap_ack_i) begin
                        state_q     <= IDLE;
                        trap_req_o  <= 1'b0;
                        stall_o     <= 1'b0;
                        trap_type_o <= TRAP_NONE;
                        multi_o     <= any_viol_c;
                    end else if (any_viol_c) begin
                        multi_o     <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DIFT_VIOLATION_CNT_EN
    // Saturating per-class counters, independent of priority and FSM state
    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (cnt_clr_i) begin
                cnt_q <= '0;
            end else if (viol_c[g] && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end

        assign cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign cnt_o          = '0;
`endif

endmodule

// File: tb/tb_dift_tag_check_ctrl.sv
// Self-checking bench for dift_tag_check_ctrl: behavioural trap model checked every cycle plus directed literals.
module tb_dift_tag_check_ctrl;

    localparam int unsigned TW = 4;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid_i;
    logic [31:0]   pc_id_i;
    logic [TW-1:0] instr_tag_i, jump_target_tag_i, operand_a_tag_i, operand_b_tag_i, tag_mask_i;
    logic [1:0]    jump_in_i, tccr_br_mode_i;
    logic          is_load_i, is_store_i;
    logic          tccr_exec_i, tccr_jalr_i, tccr_store_i, tccr_load_i, tccr_br_sel_i;
    logic          trap_ack_i, cnt_clr_i;
    logic          trap_req_o, multi_o, stall_o;
    logic [2:0]    trap_type_o;
    logic [31:0]   trap_pc_o;
    logic [5*CW-1:0] cnt_o;

    int n_pass  = 0;
    int n_total = 0;
    bit checking = 1'b0;

    dift_tag_check_ctrl #(.TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .pc_id_i(pc_id_i),
        .instr_tag_i(instr_tag_i), .jump_in_i(jump_in_i), .jump_target_tag_i(jump_target_tag_i),
        .operand_a_tag_i(operand_a_tag_i), .operand_b_tag_i(operand_b_tag_i),
        .is_load_i(is_load_i), .is_store_i(is_store_i), .tag_mask_i(tag_mask_i),
        .tccr_exec_i(tccr_exec_i), .tccr_jalr_i(tccr_jalr_i), .tccr_store_i(tccr_store_i),
        .tccr_load_i(tccr_load_i), .tccr_br_mode_i(tccr_br_mode_i), .tccr_br_sel_i(tccr_br_sel_i),
        .trap_ack_i(trap_ack_i), .trap_req_o(trap_req_o), .trap_type_o(trap_type_o),
        .trap_pc_o(trap_pc_o), .multi_o(multi_o), .stall_o(stall_o),
        .cnt_clr_i(cnt_clr_i), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic          m_pend, m_multi;
    logic [2:0]    m_type;
    logic [31:0]   m_pc;
    logic [CW-1:0] m_cnt [5];

    function automatic bit taint(input logic [TW-1:0] t);
        return (t & tag_mask_i) != 0;
    endfunction

    // Which policy classes the current ID instruction violates: index 0..4 = exec, jalr, bran, stor, load
    function automatic logic [4:0] classes();
        logic [4:0] v;
        bit br;
        v = 5'b0;
        case (tccr_br_mode_i)
            2'd1:    br = taint(operand_a_tag_i) || taint(operand_b_tag_i);
            2'd2:    br = taint(operand_a_tag_i) && taint(operand_b_tag_i);
            2'd3:    br = tccr_br_sel_i ? taint(operand_b_tag_i) : taint(operand_a_tag_i);
            default: br = 1'b0;
        endcase
        if (id_valid_i) begin
            v[0] = tccr_exec_i && taint(instr_tag_i);
            v[1] = jump_in_i == 2'd2 && tccr_jalr_i && taint(jump_target_tag_i);
            v[2] = jump_in_i == 2'd3 && br;
            v[3] = is_store_i && tccr_store_i && taint(operand_a_tag_i);
            v[4] = is_load_i && tccr_load_i && taint(operand_a_tag_i);
        end
        return v;
    endfunction

    function automatic logic [2:0] first_class(input logic [4:0] v);
        for (int i = 0; i < 5; i++) if (v[i]) return 3'(i + 1);
        return 3'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [4:0] v;
        if (!rst_n) begin
            m_pend <= 1'b0; m_multi <= 1'b0; m_type <= 3'd0; m_pc <= 32'd0;
            for (int i = 0; i < 5; i++) m_cnt[i] <= '0;
        end else begin
            v = classes();
            if (!m_pend) begin
                if (v != 0) begin
                    m_pend <= 1'b1; m_type <= first_class(v); m_pc <= pc_id_i;
                end
            end else begin
                if (v != 0) m_multi <= 1'b1;
                if (trap_ack_i) begin
                    m_pend <= 1'b0; m_type <= 3'd0;
                    if (v == 0) m_multi <= 1'b0;
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (cnt_clr_i) m_cnt[i] <= '0;
                else if (v[i] && m_cnt[i] != {CW{1'b1}}) m_cnt[i] <= m_cnt[i] + CW'(1);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Cycle compare against the model on the falling edge
    always @(negedge clk) begin
        if (checking) begin
            chk("trap_req", 32'(trap_req_o), 32'(m_pend));
            chk("stall", 32'(stall_o), 32'(m_pend));
            chk("trap_type", 32'(trap_type_o), 32'(m_type));
            chk("multi", 32'(multi_o), 32'(m_multi));
            if (m_pend) chk("trap_pc", trap_pc_o, m_pc);
`ifdef DIFT_VIOLATION_CNT_EN
            for (int i = 0; i < 5; i++) chk("cnt", 32'(cnt_o[i*CW +: CW]), 32'(m_cnt[i]));
`else
            chk("cnt_tied", 32'(cnt_o == '0), 32'd1);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid_i = 0; pc_id_i = 0; instr_tag_i = 0; jump_in_i = 0; jump_target_tag_i = 0;
        operand_a_tag_i = 0; operand_b_tag_i = 0; is_load_i = 0; is_store_i = 0;
        tccr_exec_i = 0; tccr_jalr_i = 0; tccr_store_i = 0; tccr_load_i = 0;
        tccr_br_mode_i = 0; tccr_br_sel_i = 0; trap_ack_i = 0; cnt_clr_i = 0;
    endtask

    task automatic ack_cycle();
        trap_ack_i = 1; step(); trap_ack_i = 0;
    endtask

    initial begin
        rst_n = 0; tag_mask_i = 4'hF;
        idle_inputs();
        step(); step();
        rst_n = 1;
        checking = 1'b1;
        step();
        chk("reset_req", 32'(trap_req_o), 32'd0);
        chk("reset_pc", trap_pc_o, 32'd0);

        // 1: exec violation, 1-cycle latency, ack back to idle
        tccr_exec_i = 1; instr_tag_i = 4'h1; id_valid_i = 1; pc_id_i = 32'h100;
        step(); idle_inputs();
        chk("t1_req", 32'(trap_req_o), 32'd1);
        chk("t1_type", 32'(trap_type_o), 32'd1);
        chk("t1_pc", trap_pc_o, 32'h100);
        chk("t1_stall", 32'(stall_o), 32'd1);
        ack_cycle();
        chk("t1_idle", 32'(trap_req_o), 32'd0);

        // invalid instruction with violations raises nothing; ack in IDLE ignored
        tccr_exec_i = 1; instr_tag_i = 4'hF; trap_ack_i = 1;
        step(); idle_inputs();
        chk("novalid_req", 32'(trap_req_o), 32'd0);

        // 2: exec beats jalr
        id_valid_i = 1; pc_id_i = 32'h200; tccr_exec_i = 1; instr_tag_i = 4'h1;
        jump_in_i = 2'd2; tccr_jalr_i = 1; jump_target_tag_i = 4'h2;
        step(); idle_inputs();
        chk("t2_type", 32'(trap_type_o), 32'd1);
        ack_cycle();

        // 3: SINGLE sel=B masks the taint on A; OR mode catches it
        id_valid_i = 1; pc_id_i = 32'h300; jump_in_i = 2'd3; tccr_br_mode_i = 2'd3;
        tccr_br_sel_i = 1; operand_a_tag_i = 4'h8;
        step();
        chk("t3_single", 32'(trap_req_o), 32'd0);
        tccr_br_mode_i = 2'd1;
        step(); idle_inputs();
        chk("t3_or_type", 32'(trap_type_o), 32'd3);
        ack_cycle();

        // 4: store taint depends on mask
        tag_mask_i = 4'h1; id_valid_i = 1; pc_id_i = 32'h400; is_store_i = 1;
        tccr_store_i = 1; operand_a_tag_i = 4'hE;
        step();
        chk("t4_mask1", 32'(trap_req_o), 32'd0);
        tag_mask_i = 4'h2;
        step(); idle_inputs();
        chk("t4_type", 32'(trap_type_o), 32'd4);

        // 5: load violation while pending, TCCR change does not disturb capture
        id_valid_i = 1; pc_id_i = 32'h500; is_load_i = 1; tccr_load_i = 1; operand_a_tag_i = 4'h2;
        step(); idle_inputs();
        chk("t5_multi", 32'(multi_o), 32'd1);
        chk("t5_type", 32'(trap_type_o), 32'd4);
        chk("t5_pc", trap_pc_o, 32'h400);
        ack_cycle();
        chk("t5_multi_clr", 32'(multi_o), 32'd0);

        // Violation coincident with ack: not captured, multi stays set
        id_valid_i = 1; pc_id_i = 32'h600; tccr_exec_i = 1; instr_tag_i = 4'h2;
        step();
        pc_id_i = 32'h700; trap_ack_i = 1;
        step(); idle_inputs();
        chk("ackviol_req", 32'(trap_req_o), 32'd0);
        chk("ackviol_multi", 32'(multi_o), 32'd1);

        // 6: async reset mid-REQ
        id_valid_i = 1; pc_id_i = 32'h800; tccr_exec_i = 1; instr_tag_i = 4'h2;
        step(); idle_inputs();
        chk("t6_pre", 32'(trap_req_o), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("t6_req", 32'(trap_req_o), 32'd0);
        chk("t6_stall", 32'(stall_o), 32'd0);
        chk("t6_multi", 32'(multi_o), 32'd0);
        chk("t6_type", 32'(trap_type_o), 32'd0);
        chk("t6_pc", trap_pc_o, 32'd0);
        step();
        rst_n = 1;
        step();

`ifdef DIFT_VIOLATION_CNT_EN
        // Load counter saturation and clear-over-increment
        id_valid_i = 1; pc_id_i = 32'h900; is_load_i = 1; tccr_load_i = 1; operand_a_tag_i = 4'h2;
        for (int i = 0; i < 65535; i++) step();
        chk("cnt_sat", 32'(cnt_o[4*CW +: CW]), 32'hFFFF);
        step();
        chk("cnt_hold", 32'(cnt_o[4*CW +: CW]), 32'hFFFF);
        cnt_clr_i = 1;
        step(); cnt_clr_i = 0; idle_inputs();
        chk("cnt_clr", 32'(cnt_o[4*CW +: CW]), 32'd0);
        ack_cycle();
        // Both exec and jalr counted despite priority
        id_valid_i = 1; tccr_exec_i = 1; instr_tag_i = 4'h1;
        jump_in_i = 2'd2; tccr_jalr_i = 1; jump_target_tag_i = 4'h2;
        step(); idle_inputs();
        chk("cnt_exec", 32'(cnt_o[0 +: CW]), 32'd1);
        chk("cnt_jalr", 32'(cnt_o[CW +: CW]), 32'd1);
`endif

        step(); step();
        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
